color_sel_ctrl: RTL and testbench

Controller that sequences the colour and visibility of the text-overlay block. It turns three raw push-buttons into a frame-synchronous colour index and a blink-gated text enable. Outputs are one-hot colour selects (Black…White) and a text enable, feeding the overlay's colour inputs and gating its `text_on`. Colour and blink updates take effect only on a frame-start tick, so a frame is never drawn with mixed colours.

---
 rtl/color_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/color_sel_ctrl.sv | 152 +++++++++++++++
 tb/tb_color_sel_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared constants for the text-overlay colour controller: colour index
// encoding, blink FSM states and the one-hot colour decode.
package color_pkg;

    localparam logic [2:0] IDX_BLACK   = 3'd0;
    localparam logic [2:0] IDX_BLUE    = 3'd1;
    localparam logic [2:0] IDX_GREEN   = 3'd2;
    localparam logic [2:0] IDX_CYAN    = 3'd3;
    localparam logic [2:0] IDX_RED     = 3'd4;
    localparam logic [2:0] IDX_MAGENTA = 3'd5;
    localparam logic [2:0] IDX_YELLOW  = 3'd6;
    localparam logic [2:0] IDX_WHITE   = 3'd7;

    localparam logic [2:0] IDX_RESET   = IDX_GREEN;

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_BLINK  = 1'b1
    } blink_state_t;

    // Bit n of the result is the select for colour index n (Black is bit 0).
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchroniser, consecutive-cycle debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, giving a true 2-FF chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                // DB_CYCLES-th consecutive disagreeing cycle: accept the level.
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/color_sel_ctrl.sv
// Frame-synchronous colour selector and blink controller for the text overlay;
// button presses update pending state which is applied only on tick_frame.
module color_sel_ctrl
    import color_pkg::*;
#(
    parameter int DB_CYCLES    = 500000,
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_next,
    input  logic btn_prev,
    input  logic btn_mode,
    input  logic tick_frame,
    output logic Black,
    output logic Blue,
    output logic Green,
    output logic Cyan,
    output logic Red,
    output logic Magenta,
    output logic Yellow,
    output logic White,
    output logic text_en,
    output logic blink_mode
);

    localparam int BC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

    logic w_p_next;
    logic w_p_prev;
    logic w_p_mode;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_next),
        .press   (w_p_next)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_prev),
        .press   (w_p_prev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_mode),
        .press   (w_p_mode)
    );

    // Colour index: presses accumulate in r_pend_idx; r_cur_idx takes the
    // pre-press value when a press coincides with tick_frame.
    logic [2:0] r_pend_idx;
    logic [2:0] r_cur_idx;
    logic       r_mode_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_idx  <= IDX_RESET;
            r_cur_idx   <= IDX_RESET;
            r_mode_pend <= 1'b0;
        end else begin
            if (w_p_next && !w_p_prev) begin
                r_pend_idx <= r_pend_idx + 3'd1;
            end else if (w_p_prev && !w_p_next) begin
                r_pend_idx <= r_pend_idx - 3'd1;
            end
            if (tick_frame) begin
                r_cur_idx <= r_pend_idx;
            end
            if (w_p_mode) begin
                r_mode_pend <= ~r_mode_pend;
            end
        end
    end

    blink_state_t    r_state;
    blink_state_t    w_state_nxt;
    logic            r_text_en;
    logic            w_text_en_nxt;
    logic [BC_W-1:0] r_blink_cnt;
    logic [BC_W-1:0] w_blink_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_STEADY;
            r_text_en   <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_text_en   <= w_text_en_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_text_en_nxt   = r_text_en;
        w_blink_cnt_nxt = r_blink_cnt;
        unique case (r_state)
            ST_STEADY: begin
                w_text_en_nxt   = 1'b1;
                w_blink_cnt_nxt = '0;
                if (tick_frame && r_mode_pend) begin
                    w_state_nxt = ST_BLINK;
                end
            end
            ST_BLINK: begin
                if (tick_frame) begin
                    if (!r_mode_pend) begin
                        w_state_nxt     = ST_STEADY;
                        w_text_en_nxt   = 1'b1;
                        w_blink_cnt_nxt = '0;
                    end else if (r_blink_cnt == BC_LAST) begin
                        w_text_en_nxt   = ~r_text_en;
                        w_blink_cnt_nxt = '0;
                    end else begin
                        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STEADY;
            end
        endcase
    end

    logic [7:0] w_onehot;

    always_comb begin
        w_onehot = idx_to_onehot(r_cur_idx);
    end

    assign Black   = w_onehot[IDX_BLACK];
    assign Blue    = w_onehot[IDX_BLUE];
    assign Green   = w_onehot[IDX_GREEN];
    assign Cyan    = w_onehot[IDX_CYAN];
    assign Red     = w_onehot[IDX_RED];
    assign Magenta = w_onehot[IDX_MAGENTA];
    assign Yellow  = w_onehot[IDX_YELLOW];
    assign White   = w_onehot[IDX_WHITE];

    assign text_en    = r_text_en;
    assign blink_mode = (r_state == ST_BLINK);

endmodule

// File: tb/tb_color_sel_ctrl.sv
// Directed, table-driven bench for color_sel_ctrl with DB_CYCLES=4 and
// BLINK_FRAMES=2, plus hand-written sequences for bounce and timing corners.
module tb_color_sel_ctrl;

    localparam logic [7:0] C_BLACK = 8'b0000_0001;
    localparam logic [7:0] C_GREEN = 8'b0000_0100;
    localparam logic [7:0] C_CYAN  = 8'b0000_1000;
    localparam logic [7:0] C_WHITE = 8'b1000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_next = 1'b0;
    logic btn_prev = 1'b0;
    logic btn_mode = 1'b0;
    logic tick_frame = 1'b0;
    logic Black, Blue, Green, Cyan, Red, Magenta, Yellow, White;
    logic text_en, blink_mode;

    always #5 clk = ~clk;

    color_sel_ctrl #(.DB_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_mode   (btn_mode),
        .tick_frame (tick_frame),
        .Black      (Black),
        .Blue       (Blue),
        .Green      (Green),
        .Cyan       (Cyan),
        .Red        (Red),
        .Magenta    (Magenta),
        .Yellow     (Yellow),
        .White      (White),
        .text_en    (text_en),
        .blink_mode (blink_mode)
    );

    wire [7:0] colors = {White, Yellow, Magenta, Red, Cyan, Green, Blue, Black};

    typedef struct {
        logic       rst;
        logic       nxt;
        logic       prv;
        logic       mde;
        logic       tick;
        logic [7:0] color;
        logic       ten;
        logic       bm;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t vecs [N_VEC];

    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp_color,
                         input logic exp_ten, input logic exp_bm);
        n_vec++;
        if (colors !== exp_color || text_en !== exp_ten || blink_mode !== exp_bm) begin
            n_err++;
            $display("FAIL %s: got colors=%b text_en=%b blink_mode=%b, expected colors=%b text_en=%b blink_mode=%b",
                     name, colors, text_en, blink_mode, exp_color, exp_ten, exp_bm);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    // Clean press: hold well past the debounce window, then release cleanly.
    task automatic press(input logic n, input logic p, input logic m);
        btn_next = n;
        btn_prev = p;
        btn_mode = m;
        repeat (10) step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_mode = 1'b0;
        repeat (10) step();
    endtask

    task automatic tick();
        tick_frame = 1'b1;
        step();
        tick_frame = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic n, input logic p,
                                input logic m, input logic t, input logic [7:0] c,
                                input logic te, input logic bm);
        vec_t v;
        v.rst = rst; v.nxt = n; v.prv = p; v.mde = m; v.tick = t;
        v.color = c; v.ten = te; v.bm = bm;
        return v;
    endfunction

    initial begin
        //              rst  nxt  prv  mde  tick color    te   bm
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, C_GREEN, 1'b1,1'b0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, C_GREEN, 1'b1,1'b0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_CYAN,  1'b1,1'b0);
        vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, C_GREEN, 1'b1,1'b0);
        vecs[4]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0, C_GREEN, 1'b1,1'b0);
        vecs[5]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0, C_GREEN, 1'b1,1'b0);
        vecs[6]  = mk(1'b0,1'b0,1'b1,1'b0,1'b1, C_WHITE, 1'b1,1'b0);
        vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1, C_BLACK, 1'b1,1'b0);
        vecs[8]  = mk(1'b0,1'b1,1'b1,1'b0,1'b1, C_BLACK, 1'b1,1'b0);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b0,1'b1);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b0,1'b1);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b0,1'b1);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b1,1'b1, C_BLACK, 1'b1,1'b0);
        vecs[17] = mk(1'b0,1'b0,1'b0,1'b1,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b1,1'b1);
        vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, C_BLACK, 1'b0,1'b1);

        step();
        do_reset(3);
        check("reset", C_GREEN, 1'b1, 1'b0);

        // Bounce: toggling every 2 cycles never holds 4 consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            repeat (2) step();
        end
        btn_next = 1'b0;
        repeat (10) step();
        tick();
        check("bounce_ignored", C_GREEN, 1'b1, 1'b0);

        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].rst) do_reset(3);
            if (vecs[i].nxt || vecs[i].prv || vecs[i].mde)
                press(vecs[i].nxt, vecs[i].prv, vecs[i].mde);
            if (vecs[i].tick) tick();
            check($sformatf("vec%0d", i), vecs[i].color, vecs[i].ten, vecs[i].bm);
        end

        // Reset while text_en is low in BLINK: one reset cycle restores all.
        check("pre_reset_blink_low", C_BLACK, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_blink", C_GREEN, 1'b1, 1'b0);

        // Press pulse coincides with tick_frame: pulse appears 6 edges after
        // the raw rise and is applied on edge 7, together with the tick.
        repeat (3) step();
        btn_next = 1'b1;
        repeat (6) step();
        tick_frame = 1'b1;
        step();
        tick_frame = 1'b0;
        check("press_on_tick_deferred", C_GREEN, 1'b1, 1'b0);
        repeat (4) step();
        btn_next = 1'b0;
        repeat (10) step();
        check("no_change_without_tick", C_GREEN, 1'b1, 1'b0);
        tick();
        check("press_on_tick_applied", C_CYAN, 1'b1, 1'b0);

        // Back-to-back ticks with blink: enter BLINK, then ticks 2 and 3.
        press(1'b0, 1'b0, 1'b1);
        tick();
        check("b2b_tick1", C_CYAN, 1'b1, 1'b1);
        tick_frame = 1'b1;
        step();
        check("b2b_tick2", C_CYAN, 1'b1, 1'b1);
        step();
        tick_frame = 1'b0;
        check("b2b_tick3", C_CYAN, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
